// File: rtl/shade_accumulator_pkg.sv
// Shared colour/pixel types and default sizes for the shading pipeline.
// Defaults for X/Y widths must match the ray generator.
package shade_accumulator_pkg;

  localparam int DEF_NUM_LIGHTS = 4;
  localparam int DEF_X_WIDTH    = 10;
  localparam int DEF_Y_WIDTH    = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  typedef struct packed {
    logic [DEF_X_WIDTH-1:0] x;
    logic [DEF_Y_WIDTH-1:0] y;
    Color                   color;
  } ShadedPixel_t;

  // Carry out of the 9-bit sum clamps the channel to full scale.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/shade_accumulator_color_sat_add.sv
// Per-channel 8-bit saturating adder for RGB; purely combinational, no backpressure.
module color_sat_add
  import shade_accumulator_pkg::*;
(
  input  Color a_i,
  input  Color b_i,
  output Color sum_o
);

  assign sum_o.r = sat_add8(a_i.r, b_i.r);
  assign sum_o.g = sat_add8(a_i.g, b_i.g);
  assign sum_o.b = sat_add8(a_i.b, b_i.b);

endmodule

// File: rtl/shade_accumulator.sv
// Sums NUM_LIGHTS shader contributions per pixel; out_valid one cycle after the last one, held until out_ready.
// Single-pixel buffer (busy while working). SHADE_ACCUM_AMBIENT_EN adds an ambient base colour input.
module shade_accumulator
  import shade_accumulator_pkg::*;
#(
  parameter int NUM_LIGHTS = DEF_NUM_LIGHTS,
  parameter int X_WIDTH    = DEF_X_WIDTH,
  parameter int Y_WIDTH    = DEF_Y_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_start,
  input  logic [X_WIDTH-1:0] pixel_x_in,
  input  logic [Y_WIDTH-1:0] pixel_y_in,
`ifdef SHADE_ACCUM_AMBIENT_EN
  input  Color               ambient_color,
`endif
  input  logic               contrib_valid,
  input  Color               contrib_color,
  output logic               out_valid,
  input  logic               out_ready,
  output ShadedPixel_t       out_pixel,
  output logic               busy,
  output logic               protocol_err
);

  localparam int CNT_WIDTH = $clog2(NUM_LIGHTS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_LIGHTS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]           state_q, state_d;
  Color                 acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic                 err_q, err_d;
  Color                 base_color;
  Color                 acc_sum;

`ifdef SHADE_ACCUM_AMBIENT_EN
  assign base_color = ambient_color;
`else
  assign base_color = '0;
`endif

  color_sat_add u_sat_add (
    .a_i   (acc_q),
    .b_i   (contrib_color),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    // Contributions are only legal in ACCUM, new pixels only in IDLE.
    err_d   = err_q | (contrib_valid && (state_q != ST_ACCUM))
                    | (pixel_start && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (pixel_start) begin
          x_d     = pixel_x_in;
          y_d     = pixel_y_in;
          acc_d   = base_color;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (contrib_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST_IDX) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign out_valid       = (state_q == ST_HOLD);
  assign busy            = (state_q != ST_IDLE);
  assign protocol_err    = err_q;
  assign out_pixel.x     = x_q;
  assign out_pixel.y     = y_q;
  assign out_pixel.color = acc_q;

endmodule

// File: tb/tb_shade_accumulator.sv
// Table-driven bench for shade_accumulator with an output scoreboard and hand-written corner sequences.
module tb_shade_accumulator;
  import shade_accumulator_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         pixel_start;
  logic [9:0]   pixel_x_in;
  logic [9:0]   pixel_y_in;
  Color         ambient_color;
  logic         contrib_valid;
  Color         contrib_color;
  logic         out_valid;
  logic         out_ready;
  ShadedPixel_t out_pixel;
  logic         busy;
  logic         protocol_err;

  int n_vec = 0;
  int n_err = 0;
  ShadedPixel_t exp_q[$];

  always #5 clk = ~clk;

  shade_accumulator dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_start   (pixel_start),
    .pixel_x_in    (pixel_x_in),
    .pixel_y_in    (pixel_y_in),
`ifdef SHADE_ACCUM_AMBIENT_EN
    .ambient_color (ambient_color),
`endif
    .contrib_valid (contrib_valid),
    .contrib_color (contrib_color),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pixel     (out_pixel),
    .busy          (busy),
    .protocol_err  (protocol_err)
  );

  typedef struct {
    logic [9:0]     x;
    logic [9:0]     y;
    Color           amb;
    Color [3:0]     c;
    Color           exp_color;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic Color mk(input int r, input int g, input int b);
    Color c;
    c.r = 8'(r); c.g = 8'(g); c.b = 8'(b);
    return c;
  endfunction

  function automatic ShadedPixel_t mkpx(input int x, input int y, input Color c);
    ShadedPixel_t p;
    p.x = 10'(x); p.y = 10'(y); p.color = c;
    return p;
  endfunction

  task automatic start_px(input int x, input int y, input Color amb);
    pixel_start   = 1'b1;
    pixel_x_in    = 10'(x);
    pixel_y_in    = 10'(y);
    ambient_color = amb;
    tick();
    pixel_start   = 1'b0;
  endtask

  task automatic feed(input Color c);
    contrib_valid = 1'b1;
    contrib_color = c;
    tick();
    contrib_valid = 1'b0;
  endtask

  // Scoreboard: every handshake must match the oldest pending expected pixel.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(out_pixel), 64'hDEAD);
      end else begin
        chk("sb_pixel", 64'(out_pixel), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    ShadedPixel_t held;

`ifdef SHADE_ACCUM_AMBIENT_EN
    vecs[0] = '{x: 10'd12,   y: 10'd34, amb: mk(16,16,16),
                c: {4{mk(10,10,10)}}, exp_color: mk(56,56,56)};
    vecs[1] = '{x: 10'd1,    y: 10'd2,  amb: mk(250,0,0),
                c: {mk(0,0,0), mk(0,0,0), mk(0,0,0), mk(10,0,0)}, exp_color: mk(255,0,0)};
    vecs[2] = '{x: 10'd1023, y: 10'd0,  amb: mk(0,0,0),
                c: {mk(0,0,1), mk(0,60,255), mk(100,100,0), mk(200,100,0)}, exp_color: mk(255,255,255)};
    vecs[3] = '{x: 10'd5,    y: 10'd7,  amb: mk(1,1,1),
                c: {mk(1,2,3), mk(0,0,0), mk(5,6,7), mk(50,60,70)}, exp_color: mk(57,69,81)};
`else
    vecs[0] = '{x: 10'd12,   y: 10'd34,   amb: mk(0,0,0),
                c: {4{mk(10,20,30)}}, exp_color: mk(40,80,120)};
    vecs[1] = '{x: 10'd1023, y: 10'd0,    amb: mk(0,0,0),
                c: {mk(0,0,1), mk(0,60,255), mk(100,100,0), mk(200,100,0)}, exp_color: mk(255,255,255)};
    vecs[2] = '{x: 10'd0,    y: 10'd1023, amb: mk(0,0,0),
                c: {4{mk(0,0,0)}}, exp_color: mk(0,0,0)};
    vecs[3] = '{x: 10'd5,    y: 10'd7,    amb: mk(0,0,0),
                c: {mk(1,2,3), mk(0,0,0), mk(5,6,7), mk(50,60,70)}, exp_color: mk(56,68,80)};
`endif

    reset = 1'b1; pixel_start = 1'b0; pixel_x_in = '0; pixel_y_in = '0;
    ambient_color = '0; contrib_valid = 1'b0; contrib_color = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pixel", 64'(out_pixel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(protocol_err), 64'd0);
    reset = 1'b0;
    tick();

    // Table vectors: contributions on consecutive cycles (c[0] first), ready held high.
    for (int i = 0; i < 4; i++) begin
      start_px(vecs[i].x, vecs[i].y, vecs[i].amb);
      exp_q.push_back(mkpx(vecs[i].x, vecs[i].y, vecs[i].exp_color));
      chk("vec_busy", 64'(busy), 64'd1);
      for (int k = 0; k < 4; k++) begin
        chk("vec_no_early_valid", 64'(out_valid), 64'd0);
        feed(vecs[i].c[k]);
      end
      chk("vec_out_valid", 64'(out_valid), 64'd1);
      chk("vec_color", 64'(out_pixel.color), 64'(vecs[i].exp_color));
      tick();
      chk("vec_idle_after", 64'(busy), 64'd0);
    end
    chk("err_clean", 64'(protocol_err), 64'd0);
    ambient_color = '0;

    // Backpressure with a stray contribution in HOLD.
    out_ready = 1'b0;
    start_px(3, 4, mk(0,0,0));
    exp_q.push_back(mkpx(3, 4, mk(28,24,20)));
    for (int k = 0; k < 4; k++) feed(mk(7,6,5));
    held = out_pixel;
    chk("bp_first_pixel", 64'(held), 64'(mkpx(3, 4, mk(28,24,20))));
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_pixel_held", 64'(out_pixel), 64'(held));
      if (k == 1) feed(mk(99,99,99));
      else tick();
    end
    chk("bp_err_set", 64'(protocol_err), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_idle", 64'(busy), 64'd0);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);

    // Reset after 2 of 4 contributions discards the pixel.
    start_px(50, 60, mk(0,0,0));
    exp_q.push_back(mkpx(50, 60, mk(0,0,0)));
    feed(mk(90,90,90)); feed(mk(90,90,90));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pixel", 64'(out_pixel), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(protocol_err), 64'd0);

    // Fresh pixel: simultaneous start+contrib is dropped, gaps leave accumulator unchanged.
    contrib_valid = 1'b1; contrib_color = mk(100,100,100);
    start_px(8, 9, mk(0,0,0));
    contrib_valid = 1'b0;
    exp_q.push_back(mkpx(8, 9, mk(4,4,4)));
    chk("start_contrib_err", 64'(protocol_err), 64'd1);
    for (int k = 0; k < 4; k++) begin
      feed(mk(1,1,1));
      tick();
    end
    chk("fresh_color", 64'(out_pixel), 64'(mkpx(8, 9, mk(4,4,4))));
    tick();

    // pixel_start while busy is ignored, including the HOLD handshake cycle.
    start_px(100, 200, mk(0,0,0));
    exp_q.push_back(mkpx(100, 200, mk(8,8,8)));
    feed(mk(2,2,2));
    start_px(300, 400, mk(0,0,0));
    chk("busy_start_xy", 64'({out_pixel.x, out_pixel.y}), 64'({10'd100, 10'd200}));
    for (int k = 0; k < 3; k++) feed(mk(2,2,2));
    chk("busy_start_pixel", 64'(out_pixel), 64'(mkpx(100, 200, mk(8,8,8))));
    start_px(111, 222, mk(0,0,0));
    chk("hold_start_ignored", 64'(busy), 64'd0);
    chk("err_sticky", 64'(protocol_err), 64'd1);
    tick(); tick();
    chk("err_still_sticky", 64'(protocol_err), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 64'(protocol_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shade_accumulator.md
Name: shade_accumulator

Overview:
- Sits directly downstream of the Lambertian shading stage.
- Accumulates per-light 8-bit RGB contributions for one pixel using per-channel saturating addition.
- After NUM_LIGHTS contributions, presents the finished pixel color with its screen coordinates to the framebuffer writer over a valid/ready handshake.
- Provides single-pixel buffering; the upstream scheduler must not start a new pixel while busy=1.

Parameters:
- NUM_LIGHTS, 4, contributions summed per pixel; legal range 1..255.
- X_WIDTH, 10, width of the pixel x coordinate.
- Y_WIDTH, 10, width of the pixel y coordinate.
- CNT_WIDTH (localparam), $clog2(NUM_LIGHTS+1), width of the contribution counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pixel_start  in  1  begin a new pixel; honoured only in IDLE.
- pixel_x_in  in  X_WIDTH  pixel x coordinate, sampled with pixel_start.
- pixel_y_in  in  Y_WIDTH  pixel y coordinate, sampled with pixel_start.
- contrib_valid  in  1  one shader result present this cycle.
- contrib_color  in  24 (Color)  shader result {r,g,b}, 8 bits each.
- out_valid  out  1  finished pixel available.
- out_ready  in  1  downstream accepts the pixel.
- out_pixel  out  ShadedPixel_t  {x, y, color}.
- busy  out  1  high in ACCUM and HOLD.
- protocol_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Clocking: all state is registered on posedge clk. reset is synchronous, active-high, clock clk.
- Reset values: state=IDLE, out_valid=0, out_pixel=0, busy=0, protocol_err=0, accumulator=0, counter=0.
- Reset asserted mid-operation discards the pixel in flight. No output is produced for it.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - On pixel_start: latch x and y, load the accumulator with its base value (0, or ambient; see Optional Feature), clear the counter, go to ACCUM.
  - contrib_valid in IDLE: contribution is dropped and protocol_err is set.
- ACCUM:
  - Each cycle with contrib_valid: for each channel, form a 9-bit sum acc+contrib. If bit 8 is set, the result is 8'hFF; otherwise it is sum[7:0]. Counter increments.
  - When the accepted contribution is the NUM_LIGHTS-th one, go to HOLD. out_valid rises the next cycle, and out_pixel.color includes that final contribution.
  - Latency: last contrib_valid at cycle t gives out_valid=1 at cycle t+1.
  - With NUM_LIGHTS=1, the first contribution goes directly to HOLD.
  - Gaps (contrib_valid=0) are allowed and leave the accumulator unchanged.
- HOLD:
  - out_valid=1. out_pixel remains stable until a cycle with out_ready=1.
  - That handshake cycle returns to IDLE; out_valid=0 from the next cycle.
  - out_valid never drops without a handshake.
  - contrib_valid in HOLD is dropped and sets protocol_err.
- pixel_start while busy=1, including the HOLD handshake cycle: ignored and sets protocol_err. The upstream scheduler waits for busy=0.
- contrib_valid and pixel_start together in IDLE: the pixel starts and the contribution is dropped with protocol_err set. Contributions are accepted only from the cycle after pixel_start.
- busy is combinational from state (state != IDLE).

Optional Feature:
- Macro: SHADE_ACCUM_AMBIENT_EN.
- Defined:
  - Adds input port ambient_color (24-bit Color), sampled with pixel_start.
  - The accumulator is loaded with ambient_color instead of 0, so the output is sat(ambient + sum of contributions).
- Undefined:
  - The port is absent and the accumulator base is 0.

Decomposition:
- Shared Types package:
  - Color (r, g, b; 8 bits each).
  - New struct ShadedPixel_t {x [X_WIDTH-1:0], y [Y_WIDTH-1:0], color Color}, using default widths from Parameters.
- Parameters package: NUM_LIGHTS default, and X_WIDTH/Y_WIDTH defaults shared with the ray generator.
- Sub-module color_sat_add:
  - Combinational, 3×8-bit per-channel saturating adder.
  - Reused later by the framebuffer blend stage.
- The FSM, counter, and registers stay in shade_accumulator.

Test Plan:
- Basic accumulation: NUM_LIGHTS=4, pixel_start with x=12, y=34; contributions {10,20,30}×4 on consecutive cycles; out_ready=1 → out_valid one cycle after the 4th contribution; out_pixel={12,34,{40,80,120}}; busy=0 the following cycle.
- Saturation: contributions {200,100,0}, {100,100,0}, {0,60,255}, {0,0,1} → color {255,255,255}; no wrap-around.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_pixel held constant and out_valid stays 1; a stray contrib_valid in this window is dropped and sets protocol_err; handshake on cycle 6 → IDLE.
- Reset mid-operation: reset after 2 of 4 contributions → all outputs zero next cycle; a fresh pixel with 4×{1,1,1} yields {4,4,4}, with no residue from the aborted pixel.
- Protocol errors: pixel_start while busy → ignored, latched x/y unchanged, protocol_err=1; error stays set until reset.
- SHADE_ACCUM_AMBIENT_EN defined: ambient {16,16,16}, 4×{10,10,10} → {56,56,56}; ambient {250,0,0} plus {10,0,0} → {255,0,0}.
